// File: rtl/secure_boot_pkg.sv
// secure_boot_pkg: definitions shared by the bootloader flash responder and
// its word array. It provides the bootloader region placement and size, the
// default unlock key, the erased-word value and the command FSM state type.
// It also provides a helper that decides whether a byte address selects a
// valid word of a region.
package secure_boot_pkg;

    localparam logic [31:0] BOOTLOADER_START = 32'h1000_0000;
    localparam int unsigned BOOTLOADER_SIZE  = 32'd4096;       // bytes
    localparam logic [31:0] SECURE_KEY       = 32'h1234_5678;
    localparam logic [31:0] ERASED_WORD      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        ERASE = 2'd2
    } flash_state_e;

    // True when addr is word aligned and lies in [base, base + span_bytes).
    // The offset form avoids overflow of base + span near the top of memory.
    function automatic logic word_addr_ok(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] span_bytes);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < span_bytes) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/flash_word_array.sv
// flash_word_array: word storage behind the bootloader flash responder.
// It has one synchronous read port and one synchronous write port. The array
// powers up erased. The contents are never reset.
//   clk_i, rst_i      clock; rst_i only clears the read data register
//   rd_en_i/rd_addr_i read request; rd_data_o is valid the next cycle, else 0
//   wr_en_i           write strobe
//   wr_clear_only_i   1: program (bits can only clear), 0: plain overwrite
//   wr_addr_i/wr_data_i write word index and data
module flash_word_array
    import secure_boot_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10,
    parameter string       INIT_FILE   = ""
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    input  logic          wr_en_i,
    input  logic          wr_clear_only_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i
);

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: ERASED_WORD};
    logic [31:0] rd_data_q;

    // Registered read port; it returns zero on cycles with no read request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= 32'd0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= 32'd0;
        end
    end

    // Write port. Programming ANDs the data into the stored word, as flash does.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_clear_only_i) begin
                mem_q[wr_addr_i] <= mem_q[wr_addr_i] & wr_data_i;
            end else begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/boot_flash_responder.sv
// boot_flash_responder: flash-side responder for the bootloader fetch path.
// It serves word reads with 1-cycle latency. It also runs write-protected
// word-program and sector-erase commands from the provisioning port.
//   clk, rst (sync, active high)
//   flash_addr/flash_read_en -> flash_data/flash_data_valid/rd_error (next cycle)
//   prog_en/prog_addr/prog_data     word program (bits only clear)
//   erase_en/erase_sector           sector erase to all-ones
//   unlock_en/unlock_key            clears write protection with the right key
//   busy, wp_active, op_error       status; op_error is a 1-cycle reject pulse
module boot_flash_responder
    import secure_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BOOTLOADER_START,
    parameter int unsigned DEPTH_WORDS  = BOOTLOADER_SIZE / 4,
    parameter int unsigned SECTOR_WORDS = 64,
    parameter int unsigned WP_WORDS     = 1024,
    parameter int unsigned PROG_CYCLES  = 4,
    parameter logic [31:0] UNLOCK_KEY   = SECURE_KEY,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] flash_addr,
    input  logic        flash_read_en,
    output logic [31:0] flash_data,
    output logic        flash_data_valid,
    output logic        rd_error,
    input  logic        prog_en,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    input  logic        erase_en,
    input  logic [7:0]  erase_sector,
    input  logic        unlock_en,
    input  logic [31:0] unlock_key,
    output logic        busy,
    output logic        wp_active,
    output logic        op_error
);

    localparam int unsigned AW  = (DEPTH_WORDS  > 1) ? $clog2(DEPTH_WORDS)  : 1;
    localparam int unsigned ECW = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
    localparam int unsigned PCW = (PROG_CYCLES  > 1) ? $clog2(PROG_CYCLES)  : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

    flash_state_e   state_q;
    logic           busy_q;
    logic           wp_q;
    logic           wp_d;
    logic           op_error_q;
    logic           rd_valid_q;
    logic           rd_error_q;
    logic [PCW-1:0] prog_cnt_q;
    logic [ECW-1:0] erase_cnt_q;
    logic [AW-1:0]  prog_idx_q;
    logic [AW-1:0]  erase_base_q;
    logic [31:0]    prog_wdata_q;

    logic           rd_ok_s;
    logic           rd_bad_s;
    logic [AW-1:0]  rd_idx_s;
    logic           prog_addr_ok_s;
    logic [31:0]    prog_idx_s;
    logic           prog_wp_hit_s;
    logic [31:0]    erase_start_s;
    logic           erase_fits_s;
    logic           erase_wp_hit_s;
    logic           start_prog_s;
    logic           start_erase_s;
    logic           cmd_err_s;
    logic           key_err_s;
    logic           prog_last_s;
    logic           erase_last_s;
    logic           wr_en_s;
    logic           wr_clear_only_s;
    logic [AW-1:0]  wr_addr_s;
    logic [31:0]    wr_data_s;

    // The word index is cut to the array width only after the full-width
    // range check has been done on the byte address.
    assign rd_idx_s       = AW'((flash_addr - BASE_ADDR) >> 2);
    assign prog_addr_ok_s = word_addr_ok(prog_addr, BASE_ADDR, SPAN_BYTES);
    assign prog_idx_s     = (prog_addr - BASE_ADDR) >> 2;
    assign prog_wp_hit_s  = wp_q && (prog_idx_s < 32'(WP_WORDS));
    assign erase_start_s  = 32'(erase_sector) * 32'(SECTOR_WORDS);
    assign erase_fits_s   = erase_start_s < 32'(DEPTH_WORDS);
    // Sectors start at or above word 0, so a sector overlaps the protected
    // window exactly when its first word lies inside it.
    assign erase_wp_hit_s = wp_q && (erase_start_s < 32'(WP_WORDS));
    assign prog_last_s    = prog_cnt_q  == PCW'(PROG_CYCLES - 1);
    assign erase_last_s   = erase_cnt_q == ECW'(SECTOR_WORDS - 1);

    // Classify the read request: serve it, flag it as bad, or drop it while busy.
    always_comb begin
        rd_ok_s  = 1'b0;
        rd_bad_s = 1'b0;
        if (flash_read_en && !busy_q) begin
            if (word_addr_ok(flash_addr, BASE_ADDR, SPAN_BYTES)) begin
                rd_ok_s = 1'b1;
            end else begin
                rd_bad_s = 1'b1;
            end
        end else begin
            rd_ok_s  = 1'b0;
            rd_bad_s = 1'b0;
        end
    end

    // Command arbitration; the command sees the protection state before any same-cycle unlock.
    always_comb begin
        start_prog_s  = 1'b0;
        start_erase_s = 1'b0;
        cmd_err_s     = 1'b0;
        if (prog_en && erase_en) begin
            cmd_err_s = 1'b1;
        end else if ((prog_en || erase_en) && busy_q) begin
            cmd_err_s = 1'b1;
        end else if (prog_en) begin
            if (prog_addr_ok_s && !prog_wp_hit_s) begin
                start_prog_s = 1'b1;
            end else begin
                cmd_err_s = 1'b1;
            end
        end else if (erase_en) begin
            if (erase_fits_s && !erase_wp_hit_s) begin
                start_erase_s = 1'b1;
            end else begin
                cmd_err_s = 1'b1;
            end
        end else begin
            cmd_err_s = 1'b0;
        end
    end

    // Unlock: the right key drops protection and any other key re-arms it.
    always_comb begin
        wp_d      = wp_q;
        key_err_s = 1'b0;
        if (unlock_en) begin
            if (unlock_key == UNLOCK_KEY) begin
                wp_d      = 1'b0;
                key_err_s = 1'b0;
            end else begin
                wp_d      = 1'b1;
                key_err_s = 1'b1;
            end
        end else begin
            wp_d      = wp_q;
            key_err_s = 1'b0;
        end
    end

    // Array write port. It is held off during reset so an aborted erase stops at once.
    always_comb begin
        wr_en_s         = 1'b0;
        wr_clear_only_s = 1'b0;
        wr_addr_s       = '0;
        wr_data_s       = 32'd0;
        case (state_q)
            PROG: begin
                wr_en_s         = !rst && prog_last_s;
                wr_clear_only_s = 1'b1;
                wr_addr_s       = prog_idx_q;
                wr_data_s       = prog_wdata_q;
            end
            ERASE: begin
                wr_en_s         = !rst;
                wr_clear_only_s = 1'b0;
                wr_addr_s       = erase_base_q + AW'(erase_cnt_q);
                wr_data_s       = ERASED_WORD;
            end
            default: begin
                wr_en_s         = 1'b0;
                wr_clear_only_s = 1'b0;
                wr_addr_s       = '0;
                wr_data_s       = 32'd0;
            end
        endcase
    end

    // Command FSM with registered busy, protection and reject status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            wp_q         <= 1'b1;
            op_error_q   <= 1'b0;
            prog_cnt_q   <= '0;
            erase_cnt_q  <= '0;
            prog_idx_q   <= '0;
            erase_base_q <= '0;
            prog_wdata_q <= 32'd0;
        end else begin
            wp_q       <= wp_d;
            op_error_q <= cmd_err_s | key_err_s;
            case (state_q)
                IDLE: begin
                    if (start_prog_s) begin
                        state_q      <= PROG;
                        busy_q       <= 1'b1;
                        prog_cnt_q   <= '0;
                        prog_idx_q   <= AW'(prog_idx_s);
                        prog_wdata_q <= prog_data;
                    end else if (start_erase_s) begin
                        state_q      <= ERASE;
                        busy_q       <= 1'b1;
                        erase_cnt_q  <= '0;
                        erase_base_q <= AW'(erase_start_s);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                PROG: begin
                    if (prog_last_s) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        prog_cnt_q <= '0;
                    end else begin
                        prog_cnt_q <= prog_cnt_q + PCW'(1);
                    end
                end
                ERASE: begin
                    if (erase_last_s) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        erase_cnt_q <= '0;
                    end else begin
                        erase_cnt_q <= erase_cnt_q + ECW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read status flags, aligned with the array's registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok_s;
            rd_error_q <= rd_bad_s;
        end
    end

    flash_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk_i           (clk),
        .rst_i           (rst),
        .rd_en_i         (rd_ok_s),
        .rd_addr_i       (rd_idx_s),
        .rd_data_o       (flash_data),
        .wr_en_i         (wr_en_s),
        .wr_clear_only_i (wr_clear_only_s),
        .wr_addr_i       (wr_addr_s),
        .wr_data_i       (wr_data_s)
    );

    assign flash_data_valid = rd_valid_q;
    assign rd_error         = rd_error_q;
    assign busy             = busy_q;
    assign wp_active        = wp_q;
    assign op_error         = op_error_q;

endmodule
